// File: rtl/gige_rx_pkg.sv
// Shared constants, state encoding and payload types for the GigE RX frame delineator.
package gige_rx_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned MOD_W  = 3;
  localparam int unsigned ERR_W  = 4;

  // XGMII control characters (valid only on lanes whose ctrl bit is set)
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERR   = 8'hFE;
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_SFD   = 8'hD5;

  // Bit positions inside stat_err
  localparam int unsigned ERR_CODE  = 0;
  localparam int unsigned ERR_RUNT  = 1;
  localparam int unsigned ERR_GIANT = 2;
  localparam int unsigned ERR_TRUNC = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  // One frame word waiting in the lookahead register
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
  } rx_word_t;

  // Frame length accumulation, sticking at all-ones
  function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] len,
                                                   input logic [3:0]       add);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(add);
    return sum[LEN_W] ? '1 : sum[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/gige_rx_frm_dlm_if.sv
// Framed RX data stream plus per-frame status, from the delineator to the RX buffer manager.
interface gige_rx_frm_dlm_if;
  import gige_rx_pkg::*;

  logic [DATA_W-1:0] rx_dout;
  logic              rx_valid;
  logic              rx_sop;
  logic              rx_eop;
  logic [MOD_W-1:0]  rx_mod;
  logic              stat_valid;
  logic [LEN_W-1:0]  stat_len;
  logic [ERR_W-1:0]  stat_err;

  modport master (
    output rx_dout, rx_valid, rx_sop, rx_eop, rx_mod,
    output stat_valid, stat_len, stat_err
  );

  modport slave (
    input rx_dout, rx_valid, rx_sop, rx_eop, rx_mod,
    input stat_valid, stat_len, stat_err
  );

endinterface

// File: rtl/gige_rx_term_det.sv
// Finds the lowest lane carrying Terminate and flags any other control character below it.
module gige_rx_term_det
  import gige_rx_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              term_hit,
  output logic [MOD_W-1:0]  term_lane,
  output logic              ctrl_err
);

  // Scan lanes upward; once a Terminate is found, lanes above it are don't-care
  always_comb begin
    term_hit  = 1'b0;
    term_lane = '0;
    ctrl_err  = 1'b0;
    for (int i = 0; i < int'(CTRL_W); i++) begin
      if (!term_hit && ctrl_in[i]) begin
        if (data_in[8*i +: 8] == XG_TERM) begin
          term_hit  = 1'b1;
          term_lane = MOD_W'(i);
        end else begin
          ctrl_err = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gige_rx_frm_dlm.sv
// GigE RX frame delineator: strips start/preamble/SFD, frames data with sop/eop/mod, reports per-frame status.
// Optional statistics counters are built when GIGE_RX_FRM_STATS_EN is defined.
module gige_rx_frm_dlm
  import gige_rx_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  gige_rx_frm_dlm_if.master rx
`ifdef GIGE_RX_FRM_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stat_frm_ok,
  output logic [CNT_W-1:0]  stat_frm_err,
  output logic [CNT_W-1:0]  stat_bytes
`endif
);

  if (CNT_W < LEN_W) begin : g_cnt_w_chk
    $error("CNT_W must be at least as wide as the frame length");
  end

  state_e            state, state_nxt;
  rx_word_t          hold, hold_nxt;
  logic              hold_vld, hold_vld_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic              code, code_nxt;

  logic              term_hit;
  logic [MOD_W-1:0]  term_lane;
  logic              ctrl_err;

  logic              lane0_start;
  logic              good_start;
  logic              emit;
  logic              emit_eop;
  logic              trunc;
  logic [ERR_W-1:0]  err_vec;

  gige_rx_term_det u_term_det (
    .data_in   (data_in),
    .ctrl_in   (ctrl_in),
    .term_hit  (term_hit),
    .term_lane (term_lane),
    .ctrl_err  (ctrl_err)
  );

  assign lane0_start = ctrl_in[0] && (data_in[7:0] == XG_START);
  assign good_start  = (ctrl_in == 8'h01) && (data_in[7:0] == XG_START) &&
                       (data_in[DATA_W-1 -: 8] == XG_SFD);

  // Next state, lookahead register and output selection. The held word always
  // leaves the next cycle; the incoming word decides whether it leaves as eop.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = '0;
    hold_vld_nxt = 1'b0;
    len_nxt      = len;
    code_nxt     = code;
    emit         = hold_vld;
    emit_eop     = hold.eop;
    trunc        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (good_start) begin
          state_nxt = ST_DATA;
          len_nxt   = '0;
          code_nxt  = 1'b0;
        end
      end

      ST_DATA: begin
        if (lane0_start) begin
          // New start inside a frame: close what we have as truncated
          state_nxt = ST_IDLE;
          emit_eop  = hold_vld;
          trunc     = hold_vld;
        end else if (term_hit) begin
          state_nxt = ST_IDLE;
          code_nxt  = code | ctrl_err;
          if (term_lane == '0) begin
            emit_eop = hold_vld;
          end else begin
            hold_vld_nxt = 1'b1;
            hold_nxt     = '{data: data_in, sop: !hold_vld, eop: 1'b1, mod: term_lane};
            len_nxt      = len_sat_add(len, {1'b0, term_lane});
          end
        end else begin
          hold_vld_nxt = 1'b1;
          hold_nxt     = '{data: data_in, sop: !hold_vld, eop: 1'b0, mod: '0};
          len_nxt      = len_sat_add(len, 4'd8);
          code_nxt     = code | ctrl_err;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    err_vec            = '0;
    err_vec[ERR_CODE]  = code;
    err_vec[ERR_RUNT]  = len < LEN_W'(MIN_LEN);
    err_vec[ERR_GIANT] = len > LEN_W'(MAX_LEN);
    err_vec[ERR_TRUNC] = trunc;
  end

  // State, lookahead and registered outputs
  always_ff @(posedge clk) begin
    if (reset_) begin
      state         <= ST_IDLE;
      hold          <= '0;
      hold_vld      <= 1'b0;
      len           <= '0;
      code          <= 1'b0;
      rx.rx_dout    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.rx_sop     <= 1'b0;
      rx.rx_eop     <= 1'b0;
      rx.rx_mod     <= '0;
      rx.stat_valid <= 1'b0;
      rx.stat_len   <= '0;
      rx.stat_err   <= '0;
    end else begin
      state         <= state_nxt;
      hold          <= hold_nxt;
      hold_vld      <= hold_vld_nxt;
      len           <= len_nxt;
      code          <= code_nxt;
      rx.rx_dout    <= emit ? hold.data : '0;
      rx.rx_valid   <= emit;
      rx.rx_sop     <= emit && hold.sop;
      rx.rx_eop     <= emit && emit_eop;
      rx.rx_mod     <= (emit && emit_eop) ? hold.mod : '0;
      rx.stat_valid <= emit && emit_eop;
      rx.stat_len   <= (emit && emit_eop) ? len : '0;
      rx.stat_err   <= (emit && emit_eop) ? err_vec : '0;
    end
  end

`ifdef GIGE_RX_FRM_STATS_EN
  logic [CNT_W:0] bytes_sum;

  assign bytes_sum = {1'b0, stat_bytes} + (CNT_W+1)'(rx.stat_len);

  // Saturating frame/byte counters; clear wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset_ || stats_clr) begin
      stat_frm_ok  <= '0;
      stat_frm_err <= '0;
      stat_bytes   <= '0;
    end else if (rx.stat_valid) begin
      if (rx.stat_err == '0) begin
        if (!(&stat_frm_ok)) stat_frm_ok <= stat_frm_ok + CNT_W'(1);
      end else begin
        if (!(&stat_frm_err)) stat_frm_err <= stat_frm_err + CNT_W'(1);
      end
      stat_bytes <= bytes_sum[CNT_W] ? '1 : bytes_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_gige_rx_frm_dlm.sv
// Randomized scoreboard bench for gige_rx_frm_dlm: frames are described at byte level,
// expected words/status are queued at issue time and checked by an independent monitor.
module tb_gige_rx_frm_dlm;
  import gige_rx_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic [63:0] data_in = {8{8'h07}};
  logic [7:0]  ctrl_in = 8'hFF;
  bit          mon_en = 1'b0;

  gige_rx_frm_dlm_if rx();

  gige_rx_frm_dlm dut (
    .clk     (clk),
    .reset_  (reset_),
    .data_in (data_in),
    .ctrl_in (ctrl_in),
    .rx      (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    int          cyc;
  } wexp_t;

  typedef struct {
    logic [15:0] len;
    logic [3:0]  err;
    int          cyc;
  } sexp_t;

  wexp_t wq[$];
  sexp_t sq[$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(posedge clk);
    #1;
    data_in = d;
    ctrl_in = c;
  endtask

  task automatic idle_words(input int n);
    for (int i = 0; i < n; i++) drive({8{XG_IDLE}}, 8'hFF);
  endtask

  // Builds one frame from its byte count, drives it, and queues what a correct delineator produces.
  // trunc_w > 0: that many full data words, then a fresh start word instead of a terminate.
  task automatic send_frame(input int nbytes, input bit inj, input int trunc_w, input bit bad_sfd);
    logic [63:0] w[$];
    logic [7:0]  c[$];
    logic [63:0] tmp;
    logic [7:0]  sfd, ch;
    logic [3:0]  err;
    int nf, rem, nout, ew, el, len, s;
    if (trunc_w > 0) begin
      nf = trunc_w; rem = 0;
    end else begin
      nf = nbytes / 8; rem = nbytes % 8;
    end
    for (int i = 0; i < nf; i++) begin
      w.push_back(rnd64()); c.push_back(8'h00);
    end
    nout = nf + ((rem > 0) ? 1 : 0);
    if (rem > 0) begin
      tmp = rnd64();
      for (int l = rem; l < 8; l++) tmp[8*l +: 8] = (l == rem) ? XG_TERM : XG_IDLE;
      w.push_back(tmp); c.push_back(8'(8'hFF << rem));
    end
    if (inj && nout > 0) begin
      ew = $urandom_range(nout - 1, 0);
      el = $urandom_range((rem > 0 && ew == nout - 1) ? rem - 1 : 7, 0);
      case ($urandom_range(2, 0))
        0: ch = XG_ERR;
        1: ch = XG_IDLE;
        default: ch = 8'h9C;
      endcase
      tmp = w[ew]; tmp[8*el +: 8] = ch; w[ew] = tmp;
      c[ew] = c[ew] | 8'(1 << el);
    end
    if (trunc_w > 0) begin
      w.push_back({XG_SFD, rnd64()[47:0], XG_START}); c.push_back(8'h01);
    end else if (rem == 0) begin
      w.push_back({{7{XG_IDLE}}, XG_TERM}); c.push_back(8'hFF);
    end
    len = (trunc_w > 0) ? 8 * nf : nbytes;
    if (len > 65535) len = 65535;
    err = {trunc_w > 0, len > 1518, len < 64, inj && nout > 0};
    sfd = bad_sfd ? 8'(XG_SFD ^ (8'h01 << $urandom_range(7, 0))) : XG_SFD;
    tmp = rnd64();
    drive({sfd, tmp[47:0], XG_START}, 8'h01);
    s = cyc;
    if (!bad_sfd && nout > 0) begin
      for (int i = 0; i < nout; i++)
        wq.push_back('{d: w[i], sop: (i == 0), eop: (i == nout - 1),
                       mod: (i == nout - 1) ? 3'(rem) : 3'd0, cyc: s + 3 + i});
      sq.push_back('{len: 16'(len), err: err, cyc: s + 2 + nout});
    end
    foreach (w[i]) drive(w[i], c[i]);
  endtask

  task automatic check_outputs_zero(input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(rx.rx_valid), 64'd0);
    chk({nm, "_sop_eop_mod"}, 64'({rx.rx_sop, rx.rx_eop, rx.rx_mod}), 64'd0);
    chk({nm, "_dout"}, rx.rx_dout, 64'd0);
    chk({nm, "_stat"}, 64'({rx.stat_valid, rx.stat_len, rx.stat_err}), 64'd0);
  endtask

  // Reset asserted together with the 4th data word: words 1-2 already left, the rest is lost.
  task automatic reset_mid_frame();
    logic [63:0] w1, w2, tmp;
    int s;
    tmp = rnd64();
    drive({XG_SFD, tmp[47:0], XG_START}, 8'h01);
    s = cyc;
    w1 = rnd64(); w2 = rnd64();
    wq.push_back('{d: w1, sop: 1'b1, eop: 1'b0, mod: 3'd0, cyc: s + 3});
    wq.push_back('{d: w2, sop: 1'b0, eop: 1'b0, mod: 3'd0, cyc: s + 4});
    drive(w1, 8'h00);
    drive(w2, 8'h00);
    drive(rnd64(), 8'h00);
    drive(rnd64(), 8'h00);
    reset_ = 1'b1;
    idle_words(2);
    check_outputs_zero("mid_reset");
    drive({8{XG_IDLE}}, 8'hFF);
    reset_ = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a word or a status
  always @(negedge clk) begin : mon
    wexp_t e;
    sexp_t t;
    logic [63:0] m;
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_word: got nothing by cycle %0d, required word %0h at cycle %0d",
                 cyc, wq[0].d, wq[0].cyc);
        wq.delete(0);
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_stat: got nothing by cycle %0d, required len %0d at cycle %0d",
                 cyc, sq[0].len, sq[0].cyc);
        sq.delete(0);
      end
      if (rx.rx_valid) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got %0h at cycle %0d, required no output", rx.rx_dout, cyc);
        end else begin
          e = wq.pop_front();
          m = (e.eop && e.mod != 3'd0) ? ((64'd1 << (8 * e.mod)) - 64'd1) : '1;
          chk("word_cycle", 64'(cyc), 64'(e.cyc));
          chk("rx_dout", rx.rx_dout & m, e.d & m);
          chk("rx_sop", 64'(rx.rx_sop), 64'(e.sop));
          chk("rx_eop", 64'(rx.rx_eop), 64'(e.eop));
          chk("rx_mod", 64'(rx.rx_mod), 64'(e.mod));
        end
      end
      if (rx.stat_valid) begin
        if (sq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_stat: got len %0d at cycle %0d, required no status", rx.stat_len, cyc);
        end else begin
          t = sq.pop_front();
          chk("stat_cycle", 64'(cyc), 64'(t.cyc));
          chk("stat_len", 64'(rx.stat_len), 64'(t.len));
          chk("stat_err", 64'(rx.stat_err), 64'(t.err));
        end
      end else begin
        chk("stat_idle", 64'({rx.stat_len, rx.stat_err}), 64'd0);
      end
      chk("stat_valid_vs_eop", 64'(rx.stat_valid), 64'(rx.rx_valid && rx.rx_eop));
      if (!rx.rx_eop) chk("mod_not_eop", 64'(rx.rx_mod), 64'd0);
    end
  end

  initial begin : stim
    int nb, tw, sel;
    bit inj, bad;
    idle_words(3);
    check_outputs_zero("reset");
    drive({8{XG_IDLE}}, 8'hFF);
    reset_ = 1'b0;
    mon_en = 1'b1;
    idle_words(2);

    // Directed frames around the length and framing boundaries
    send_frame(64,   1'b0, 0, 1'b0); idle_words(1);
    send_frame(65,   1'b0, 0, 1'b0); idle_words(1);
    send_frame(40,   1'b0, 0, 1'b0); idle_words(1);
    send_frame(1520, 1'b0, 0, 1'b0); idle_words(1);
    send_frame(64,   1'b1, 0, 1'b0); idle_words(1);
    send_frame(64,   1'b0, 0, 1'b1); idle_words(1);
    send_frame(0,    1'b0, 3, 1'b0); idle_words(1);
    reset_mid_frame();
    idle_words(1);
    send_frame(64,   1'b0, 0, 1'b0); idle_words(1);
    send_frame(0,    1'b0, 0, 1'b0); idle_words(1);
    send_frame(5,    1'b0, 0, 1'b0);
    send_frame(63,   1'b0, 0, 1'b0);
    send_frame(1518, 1'b0, 0, 1'b0);
    send_frame(1519, 1'b0, 0, 1'b0); idle_words(1);
    send_frame(65600, 1'b0, 0, 1'b0); idle_words(2);

    // Random frames, including back-to-back starts
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(9, 0);
      tw  = 0;
      bad = 1'b0;
      inj = ($urandom_range(3, 0) == 0);
      case (sel)
        0:       nb = $urandom_range(16, 0);
        1, 2, 3, 4, 5: nb = $urandom_range(200, 1);
        6:       nb = $urandom_range(1560, 1480);
        7: begin nb = 0; tw = $urandom_range(12, 1); end
        8: begin nb = $urandom_range(80, 8); bad = 1'b1; end
        default: nb = $urandom_range(70, 60);
      endcase
      send_frame(nb, inj, tw, bad);
      idle_words($urandom_range(2, 0));
    end

    idle_words(6);
    chk("words_drained", 64'(wq.size()), 64'd0);
    chk("stats_drained", 64'(sq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gige_rx_frm_dlm.md
Name: gige_rx_frm_dlm

Overview:
- Receive frame delineator directly downstream of the GigE RX path.
- Consumes the 64-bit data / 8-bit control word stream in XGMII lane format, one word per clock. Lane 0 is bits 7:0 / ctrl bit 0.
- Strips the start/preamble/SFD word and emits a framed data stream with sop/eop/valid-byte count.
- Produces one per-frame status word (length, error flags) for the MAC RX buffer manager.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS); shorter frames flag runt.
MAX_LEN, 1518, maximum legal frame length in bytes; longer frames flag giant.
CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
clk  in  1  single clock domain
reset_  in  1  synchronous reset, active-high
data_in  in  64  RX data word, lane k = bits 8k+7:8k
ctrl_in  in  8  per-lane control flag; 1 = lane carries a control character
rx_dout  out  64  frame data, lane 0 first
rx_valid  out  1  rx_dout carries frame bytes this cycle
rx_sop  out  1  first word of frame (qualified by rx_valid)
rx_eop  out  1  last word of frame (qualified by rx_valid)
rx_mod  out  3  valid bytes in the eop word, lanes 0..mod-1; 0 = all 8; forced 0 when not eop
stat_valid  out  1  one-cycle pulse coincident with rx_eop
stat_len  out  16  frame byte count, excluding preamble/SFD, including FCS; saturates at 16'hFFFF
stat_err  out  4  {trunc, giant, runt, code}
stats_clr  in  1  clear statistics (present only with the optional feature)
stat_frm_ok, stat_frm_err, stat_bytes  out  CNT_W each  statistics (present only with the optional feature)

Behaviour:
- Control characters: Start = 0xFB, Terminate = 0xFD, Error = 0xFE, Idle = 0x07. A character is recognised only when its ctrl bit is 1.
- Reset: all outputs 0, FSM in IDLE, pipeline registers cleared. Reset mid-frame discards the frame with no eop and no stat_valid.
- FSM states:
  - IDLE
    - Valid start word: ctrl_in = 8'h01, lane0 = 0xFB, lane7 = 0xD5 (lanes 1-6 ignored) -> DATA, len = 0, errors cleared.
    - Start with a bad SFD: word dropped, stay in IDLE, no output.
    - All other words ignored.
  - DATA
    - Each word is held one cycle in a lookahead register.
    - A word with no Terminate is a data word: 8 bytes.
    - Terminate in lane k, first Terminate lane: lanes 0..k-1 are data. k = 0 makes the held previous word the eop (mod 0). k > 0 makes this word the eop (mod = k). Next state IDLE.
    - Any ctrl lane before the Terminate that is not 0xFD sets code (0xFE or any other character). The frame continues.
    - Start (0xFB, lane 0) seen in DATA: the held word is emitted as eop, trunc is set, the new start is ignored, next state IDLE.
- Latency: each data word appears on rx_dout exactly 2 clocks after it is presented on data_in. A Terminate-only word (T in lane 0) produces no output.
- sop is asserted on the first data word after the start word.
- A one-word frame (T in lane k > 0 of the first data word) gives sop = eop = 1.
- A frame with zero data bytes (start immediately followed by T in lane 0) emits nothing and sets no status.
- Length rules:
  - len accumulates 8 per data word, k on the eop word, 16-bit saturating.
  - runt = len < MIN_LEN; giant = len > MAX_LEN; both are evaluated at eop.
- stat_* are valid only while stat_valid = 1 and are 0 otherwise.
- There is no backpressure: the consumer must accept one word per clock.

Optional Feature:
GIGE_RX_FRM_STATS_EN
- Defined: adds stats_clr, stat_frm_ok, stat_frm_err and stat_bytes.
  - On stat_valid: stat_frm_ok +1 if stat_err == 0, else stat_frm_err +1; stat_bytes += stat_len.
  - All counters saturate at all-ones.
  - stats_clr zeroes all counters the next cycle and has priority over a same-cycle increment.
  - Reset zeroes all counters.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package gige_rx_pkg: XGMII character constants (START, TERM, ERR, IDLE, SFD), the stat_err bit index constants, and the FSM state encoding.
- One sub-module, gige_rx_term_det: combinational first-Terminate lane finder over data_in/ctrl_in. Outputs term_hit, term_lane[2:0] and a ctrl_err flag for non-FD ctrl lanes below term_lane.

Test Plan:
- 64-byte frame: start word (ctrl 0x01, FB,55x6,D5), 8 data words, then FD+7x07 (ctrl 0xFF) -> 8 valid words 2 clocks after input; sop on word 1, eop on word 8 with mod 0; stat_len 64, stat_err 0.
- 65-byte frame: 8 data words, then a word with 1 data byte and FD in lane 1 (ctrl 0xFE) -> 9th word eop with mod 1; stat_len 65, err 0.
- 40-byte frame (5 words, T lane 0) -> stat_len 40, stat_err 4'b0010 (runt). 1520-byte frame -> stat_len 1520, stat_err 4'b0100 (giant).
- 0xFE with ctrl bit set in lane 3 of data word 2 of a 64-byte frame -> frame still delivered, stat_err 4'b0001. Start word with lane7 = 0xD4 -> no rx_valid, no stat_valid.
- New FB start after 3 data words -> eop on word 3, stat_len 24, stat_err 4'b1010 (trunc + runt). reset_ pulsed during word 4 of a frame -> no eop, outputs 0; the following clean frame is delivered correctly.
